scoreboard_regfile: RTL and testbench

//  Parametrised register file for the pipelined core, NUM_RD read ports and one write port.

---
 rtl/scoreboard_regfile.sv | 119 +++++++++++
 tb/tb_scoreboard_regfile.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_regfile.sv
`default_nettype none
//============================================================================
// Module      : scoreboard_regfile
// Description : Multi-read, single-write register file with a per-register
//               pending (scoreboard) bit. Decode reserves a destination,
//               writeback writes data and releases the reservation. Busy
//               flags feed the hazard/stall logic; busy_cnt tracks how many
//               registers are currently reserved.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous reset, active-low
//               rd_addr    - NUM_RD packed read indices
//               rd_data    - NUM_RD packed read data (combinational)
//               rd_busy    - per read port: source pending, not written now
//               wr_en/wr_addr/wr_data - writeback port
//               rsv_en/rsv_addr       - reservation request from decode
//               rsv_stall  - reservation refused (WAW hold), combinational
//               flush      - clear every pending bit
//               busy_cnt   - registered number of pending registers
// Revision    : 1.0 - initial release
//============================================================================
module scoreboard_regfile #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_stall,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam logic c_zero_en   = (ZERO_REG != 0);
    localparam logic c_bypass_en = (BYPASS != 0);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;

    logic [NUM_REGS-1:0] w_pend_next;
    logic [ADDR_W:0]     w_cnt_next;
    logic                w_wr_ok;
    logic                w_rsv_zero;
    logic                w_rsv_ok;

    // Register 0 is architecturally constant when ZERO_REG is set, so a write
    // to it neither stores data nor releases anything.
    assign w_wr_ok    = wr_en && !(c_zero_en && (wr_addr == '0));
    assign w_rsv_zero = c_zero_en && (rsv_addr == '0);

    // WAW hold: the destination already has an outstanding producer, unless
    // that producer is retiring in this very cycle. Independent of BYPASS.
    assign rsv_stall = rsv_en && r_pend[rsv_addr] && !(wr_en && (wr_addr == rsv_addr));
    assign w_rsv_ok  = rsv_en && !rsv_stall && !flush && !w_rsv_zero;

    // Clear from writeback first, then set from reserve, so a same-cycle
    // re-reservation of the retiring register keeps it pending.
    always_comb begin
        w_pend_next = r_pend;
        if (flush) begin
            w_pend_next = '0;
        end else begin
            if (w_wr_ok)  w_pend_next[wr_addr]  = 1'b0;
            if (w_rsv_ok) w_pend_next[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_next = w_cnt_next + {{ADDR_W{1'b0}}, w_pend_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pend   <= '0;
            busy_cnt <= '0;
        end else begin
            if (w_wr_ok) r_regs[wr_addr] <= wr_data;
            r_pend   <= w_pend_next;
            busy_cnt <= w_cnt_next;
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic              w_zero;
            logic              w_hit;

            assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];
            assign w_zero = c_zero_en && (w_addr == '0);
            // With BYPASS off the in-flight write is invisible until the edge,
            // both for data and for the busy flag.
            assign w_hit  = c_bypass_en && wr_en && (wr_addr == w_addr);

            assign rd_data[p*DATA_W +: DATA_W] = w_zero ? '0 :
                                                 w_hit  ? wr_data :
                                                          r_regs[w_addr];
            assign rd_busy[p] = !w_zero && r_pend[w_addr] && !w_hit;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_regfile.sv
`default_nettype none
//============================================================================
// Module      : tb_scoreboard_regfile
// Description : Directed, self-checking bench for scoreboard_regfile with the
//               default parameters (16x16, two read ports, ZERO_REG=1,
//               BYPASS=1). Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
//============================================================================
module tb_scoreboard_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic        rsv_stall;
    logic        flush;
    logic [4:0]  busy_cnt;

    int n_checks = 0;
    int n_errors = 0;

    scoreboard_regfile #(
        .DATA_W(16), .NUM_REGS(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_stall(rsv_stall),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        // Reset held for two edges while write/reserve are requested.
        rst = 1'b0; flush = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h5555;
        rsv_en = 1'b1; rsv_addr = 4'd4;
        rd_addr = {4'd4, 4'd3};
        tick(); tick();
        idle();
        #1;
        check("rst_data", rd_data, 32'h0000_0000);
        check("rst_busy", {30'd0, rd_busy}, 32'd0);
        check("rst_cnt", {27'd0, busy_cnt}, 32'd0);
        rst = 1'b1;
        tick();

        // Write r3 with same-cycle read on both ports.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
        rd_addr = {4'd3, 4'd3};
        #1;
        check("byp_r3", rd_data, 32'hBEEF_BEEF);
        tick(); idle(); #1;
        check("stored_r3", rd_data, 32'hBEEF_BEEF);

        // Reserve r5, re-reserve stalls, writeback releases.
        rsv_en = 1'b1; rsv_addr = 4'd5;
        #1;
        check("rsv5_nostall", {31'd0, rsv_stall}, 32'd0);
        tick(); idle();
        rd_addr = {4'd5, 4'd5};
        #1;
        check("r5_busy", {30'd0, rd_busy}, 32'd3);
        check("cnt_1", {27'd0, busy_cnt}, 32'd1);
        rsv_en = 1'b1; rsv_addr = 4'd5;
        #1;
        check("rsv5_stall", {31'd0, rsv_stall}, 32'd1);
        tick(); idle(); #1;
        check("cnt_still_1", {27'd0, busy_cnt}, 32'd1);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0042;
        #1;
        check("r5_busy_bypassed", {30'd0, rd_busy}, 32'd0);
        check("r5_byp_data", rd_data, 32'h0042_0042);
        tick(); idle(); #1;
        check("cnt_0", {27'd0, busy_cnt}, 32'd0);
        check("r5_stored", rd_data, 32'h0042_0042);

        // Distinct addresses on the two ports: port1=r3, port0=r5.
        rd_addr = {4'd3, 4'd5};
        #1;
        check("two_ports", rd_data, 32'hBEEF_0042);

        // r0 write and reserve are ignored.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        rsv_en = 1'b1; rsv_addr = 4'd0;
        rd_addr = {4'd0, 4'd0};
        #1;
        check("r0_no_bypass", rd_data, 32'd0);
        check("r0_no_stall", {31'd0, rsv_stall}, 32'd0);
        tick(); idle(); #1;
        check("r0_data", rd_data, 32'd0);
        check("r0_busy", {30'd0, rd_busy}, 32'd0);
        check("r0_cnt", {27'd0, busy_cnt}, 32'd0);

        // r7 pending, then re-reserved while being written.
        rsv_en = 1'b1; rsv_addr = 4'd7;
        tick(); idle(); #1;
        check("r7_cnt", {27'd0, busy_cnt}, 32'd1);
        rsv_en = 1'b1; rsv_addr = 4'd7;
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1234;
        #1;
        check("r7_rsv_wr_nostall", {31'd0, rsv_stall}, 32'd0);
        tick(); idle();
        rd_addr = {4'd7, 4'd7};
        #1;
        check("r7_data", rd_data, 32'h1234_1234);
        check("r7_busy", {30'd0, rd_busy}, 32'd3);
        check("r7_cnt_same", {27'd0, busy_cnt}, 32'd1);

        // Reserve r1, r2, r4 -> four pending including r7.
        rsv_en = 1'b1;
        rsv_addr = 4'd1; tick();
        rsv_addr = 4'd2; tick();
        rsv_addr = 4'd4; tick();
        idle(); #1;
        check("cnt_4", {27'd0, busy_cnt}, 32'd4);

        // Flush with a reserve of r6 and a write of r2.
        flush = 1'b1;
        rsv_en = 1'b1; rsv_addr = 4'd6;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0A0A;
        rd_addr = {4'd6, 4'd2};
        #1;
        check("flush_busy_now", {30'd0, rd_busy}, 32'd0);
        tick(); idle(); #1;
        check("flush_cnt", {27'd0, busy_cnt}, 32'd0);
        check("flush_busy", {30'd0, rd_busy}, 32'd0);
        check("flush_r2", {16'd0, rd_data[15:0]}, 32'h0000_0A0A);

        // Reset in the middle of activity.
        rsv_en = 1'b1; rsv_addr = 4'd9;
        tick();
        rsv_en = 1'b1; rsv_addr = 4'd10;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h7777;
        rd_addr = {4'd9, 4'd9};
        #1;
        check("pre_rst_cnt", {27'd0, busy_cnt}, 32'd1);
        rst = 1'b0;
        tick(); idle(); rst = 1'b1;
        rd_addr = {4'd9, 4'd3};
        #1;
        check("mid_rst_data", rd_data, 32'd0);
        check("mid_rst_busy", {30'd0, rd_busy}, 32'd0);
        check("mid_rst_cnt", {27'd0, busy_cnt}, 32'd0);
        rd_addr = {4'd10, 4'd2};
        #1;
        check("mid_rst_r10_r2", {rd_data[31:16], 14'd0, rd_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
